// File: rtl/mult_pipe.sv
// mult_pipe -- fully pipelined RV64/RV32 M-extension multiplier.
//
// Handles MUL, MULH, MULHSU, MULHU and MULW. Reserved op codes 5..7 behave
// as MUL. The full 2*XLEN product is formed combinationally ahead of
// stage 0. The STAGES product registers behind it are plain shift
// registers, so the synthesizer can retime the multiplier array across
// them. All stages advance together unless the output is stalled.
//
// Parameters
//   XLEN    operand/result width, 32 or 64
//   STAGES  pipeline registers (= latency in cycles), 1..4
//   ID_W    transaction-ID width
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset (priority over flush_i)
//   flush_i      drop everything in flight plus this cycle's input
//   in_valid_i   / in_ready_o   input handshake
//   op_i         0=MUL 1=MULH 2=MULHSU 3=MULHU 4=MULW
//   operand_a_i  rs1
//   operand_b_i  rs2
//   trans_id_i   tag, returned with the result
//   out_valid_o  / out_ready_i  output handshake
//   result_o     selected product bits
//   trans_id_o   tag of the presented result
//   busy_o       at least one transaction in flight

module mult_pipe #(
  parameter int XLEN   = 64,
  parameter int STAGES = 2,
  parameter int ID_W   = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic [ID_W-1:0] trans_id_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [ID_W-1:0] trans_id_o,
  output logic            busy_o
);

  localparam int PW = 2 * XLEN;
  localparam int CW = $clog2(STAGES + 1);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_MULW   = 3'd4;

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("mult_pipe: XLEN must be 32 or 64");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("mult_pipe: STAGES must be in 1..4");
  end

  // Pipeline state. Index 0 is the first register and STAGES-1 feeds
  // the output.
  logic [STAGES-1:0]           vld_pipe;
  logic [STAGES-1:0][PW-1:0]   prod_pipe;
  logic [STAGES-1:0][2:0]      op_pipe;
  logic [STAGES-1:0][ID_W-1:0] id_pipe;
  logic [CW-1:0]               cnt;

  logic          stall, adv, accept, out_hs;
  logic          sgn_a, sgn_b;
  logic [PW-1:0] a_ext, b_ext, prod_full;

  // Handshakes. in_ready_o is combinational from out_ready_i, so the
  // producer sees back-pressure in the same cycle it arises. A bubble at
  // the output never stalls.
  assign stall      = vld_pipe[STAGES-1] & ~out_ready_i;
  assign adv        = ~stall;
  assign in_ready_o = adv;
  assign accept     = in_valid_i & in_ready_o & ~flush_i;
  assign out_hs     = out_valid_o & out_ready_i;

  // Sign extension is carried all the way to 2*XLEN bits. The low 2*XLEN
  // bits of the extended product then equal the low bits of the exact
  // signed (XLEN+1)x(XLEN+1) product, with no separate sign correction.
  assign sgn_a     = (op_i == OP_MULH) | (op_i == OP_MULHSU);
  assign sgn_b     = (op_i == OP_MULH);
  assign a_ext     = {{XLEN{sgn_a & operand_a_i[XLEN-1]}}, operand_a_i};
  assign b_ext     = {{XLEN{sgn_b & operand_b_i[XLEN-1]}}, operand_b_i};
  assign prod_full = a_ext * b_ext;

  // Valid bits clear on flush. Data registers only move with the pipe
  // and may keep stale contents behind a cleared valid bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe  <= '0;
      prod_pipe <= '0;
      op_pipe   <= '0;
      id_pipe   <= '0;
    end else begin
      if (flush_i) begin
        vld_pipe <= '0;
      end else if (adv) begin
        vld_pipe[0] <= accept;
        for (int s = 1; s < STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
      end
      if (adv) begin
        prod_pipe[0] <= prod_full;
        op_pipe[0]   <= op_i;
        id_pipe[0]   <= trans_id_i;
        for (int s = 1; s < STAGES; s++) begin
          prod_pipe[s] <= prod_pipe[s-1];
          op_pipe[s]   <= op_pipe[s-1];
          id_pipe[s]   <= id_pipe[s-1];
        end
      end
    end
  end

  // In-flight count. It always matches the number of set valid bits, so
  // busy_o does not need a reduction over the pipe.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      cnt <= '0;
    end else if (accept && !out_hs) begin
      cnt <= cnt + 1'b1;
    end else if (!accept && out_hs) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy_o = (cnt != '0);

  // Result selection after the last register.
  logic [PW-1:0]   p_last;
  logic [2:0]      op_last;
  logic [XLEN-1:0] mulw_res;

  assign p_last  = prod_pipe[STAGES-1];
  assign op_last = op_pipe[STAGES-1];

  if (XLEN == 64) begin : g_mulw64
    assign mulw_res = {{32{p_last[31]}}, p_last[31:0]};
  end else begin : g_mulw32
    assign mulw_res = p_last[XLEN-1:0];
  end

  always_comb begin
    result_o = p_last[XLEN-1:0];
    case (op_last)
      OP_MULH, OP_MULHSU, OP_MULHU: result_o = p_last[PW-1:XLEN];
      OP_MULW:                      result_o = mulw_res;
      OP_MUL:                       result_o = p_last[XLEN-1:0];
      default:                      result_o = p_last[XLEN-1:0];
    endcase
  end

  assign out_valid_o = vld_pipe[STAGES-1];
  assign trans_id_o  = id_pipe[STAGES-1];

endmodule

// File: tb/tb_mult_pipe.sv
// Testbench for mult_pipe. It builds four XLEN=64 instances with STAGES
// 1..4 (index k -> STAGES k+1) and one XLEN=32, STAGES=2 instance (k=4).
// The instances share op/operands/id/flush/reset, and each has its own
// valid and ready. The reference model works on exact 130-bit signed
// products, with signedness chosen per op.

module tb_mult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush;
  logic [2:0]  op;
  logic [63:0] a, b;
  logic [2:0]  id;
  logic [4:0]  inv, ordy;
  logic [4:0]  ir, ov, bsy;
  logic [63:0] res [5];
  logic [2:0]  tid [5];
  logic [31:0] r32;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mult_pipe #(.XLEN(64), .STAGES(g + 1), .ID_W(3)) u_dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .in_valid_i(inv[g]), .in_ready_o(ir[g]), .op_i(op),
      .operand_a_i(a), .operand_b_i(b), .trans_id_i(id),
      .out_valid_o(ov[g]), .out_ready_i(ordy[g]),
      .result_o(res[g]), .trans_id_o(tid[g]), .busy_o(bsy[g]));
  end

  mult_pipe #(.XLEN(32), .STAGES(2), .ID_W(3)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(inv[4]), .in_ready_o(ir[4]), .op_i(op),
    .operand_a_i(a[31:0]), .operand_b_i(b[31:0]), .trans_id_i(id),
    .out_valid_o(ov[4]), .out_ready_i(ordy[4]),
    .result_o(r32), .trans_id_o(tid[4]), .busy_o(bsy[4]));
  assign res[4] = {32'h0, r32};

  function automatic int stages_of(input int k);
    return (k < 4) ? k + 1 : 2;
  endfunction

  function automatic int xlen_of(input int k);
    return (k < 4) ? 64 : 32;
  endfunction

  // Reference: exact product of the operands as the op interprets them.
  function automatic logic [63:0] ref_res(input int xl, input logic [2:0] o,
                                          input logic [63:0] av, input logic [63:0] bv);
    logic signed [129:0] x, y, p;
    logic [129:0] u;
    bit as_, bs_;
    as_ = (o == 3'd1) || (o == 3'd2);
    bs_ = (o == 3'd1);
    if (xl == 32) begin
      x = as_ ? 130'($signed(av[31:0])) : 130'(av[31:0]);
      y = bs_ ? 130'($signed(bv[31:0])) : 130'(bv[31:0]);
    end else begin
      x = as_ ? 130'($signed(av)) : 130'(av);
      y = bs_ ? 130'($signed(bv)) : 130'(bv);
    end
    p = x * y;
    u = p;
    if (xl == 64) begin
      case (o)
        3'd1, 3'd2, 3'd3: return u[127:64];
        3'd4:             return {{32{u[31]}}, u[31:0]};
        default:          return u[63:0];
      endcase
    end else begin
      case (o)
        3'd1, 3'd2, 3'd3: return {32'h0, u[63:32]};
        default:          return {32'h0, u[31:0]};
      endcase
    end
  endfunction

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 4))
      0:       return 64'hFFFF_FFFF_FFFF_FFFF;
      1:       return ($urandom_range(0, 1) != 0) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
      2:       return 64'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (ov[k] !== 1'b0)  begin errors++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, ov[k]); end
      checks++; if (bsy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, bsy[k]); end
      checks++; if (ir[k] !== 1'b1)  begin errors++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", k, ir[k]); end
      checks++; if (res[k] !== 64'h0) begin errors++; $display("FAIL reset_result[%0d]: got %h expected 0", k, res[k]); end
      checks++; if (tid[k] !== 3'h0) begin errors++; $display("FAIL reset_trans_id[%0d]: got %0d expected 0", k, tid[k]); end
    end
    rst = 1'b0;
  endtask

  // Single transaction on instance k: checks latency, value, tag, and
  // that the block goes idle after the handshake.
  task automatic run_one(input int k, input logic [2:0] o, input logic [63:0] av,
                         input logic [63:0] bv, input logic [2:0] idv,
                         input logic [63:0] exp, input string nm);
    int lat;
    bit seen;
    @(posedge clk); #1;
    op = o; a = av; b = bv; id = idv; inv[k] = 1'b1; ordy[k] = 1'b1;
    @(posedge clk); #1;
    inv[k] = 1'b0; op = 3'd3; a = '1; b = '1; id = ~idv;
    lat = 1; seen = 1'b0;
    while (lat <= 12) begin
      @(negedge clk);
      if (ov[k]) begin seen = 1'b1; break; end
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!seen || lat != stages_of(k)) begin
      errors++; $display("FAIL %s latency: got %0d (seen=%0b) expected %0d", nm, lat, seen, stages_of(k));
    end
    checks++; if (res[k] !== exp) begin errors++; $display("FAIL %s result: got %h expected %h", nm, res[k], exp); end
    checks++; if (tid[k] !== idv) begin errors++; $display("FAIL %s trans_id: got %0d expected %0d", nm, tid[k], idv); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (ov[k] !== 1'b0 || bsy[k] !== 1'b0) begin
      errors++; $display("FAIL %s idle_after: got valid=%b busy=%b expected 0/0", nm, ov[k], bsy[k]);
    end
  endtask

  task automatic test_basic;
    for (int k = 0; k < 5; k++) run_one(k, 3'd0, 64'd7, 64'd6, 3'd5, 64'd42, $sformatf("basic_mul[%0d]", k));
  endtask

  task automatic test_signed;
    run_one(1, 3'd1, '1, '1, 3'd1, 64'h0, "mulh_m1_m1");
    run_one(1, 3'd3, '1, '1, 3'd2, 64'hFFFF_FFFF_FFFF_FFFE, "mulhu_ones");
    run_one(1, 3'd2, '1, 64'd2, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, "mulhsu_m1_2");
    run_one(1, 3'd4, 64'h8000_0000, 64'd1, 3'd4, 64'hFFFF_FFFF_8000_0000, "mulw64");
    run_one(1, 3'd6, 64'd7, 64'd6, 3'd6, 64'd42, "reserved_op6");
    run_one(4, 3'd4, 64'h8000_0000, 64'd1, 3'd7, 64'h8000_0000, "mulw32");
    run_one(4, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 3'd0, 64'hFFFF_FFFE, "mulhu32");
    run_one(4, 3'd1, 64'hFFFF_FFFF, 64'd2, 3'd1, 64'hFFFF_FFFF, "mulh32_m1_2");
  endtask

  // STAGES=3: six back-to-back transactions, output held off for four
  // cycles once the first result shows up.
  task automatic test_back_to_back;
    int k, sent, recv, hold;
    bit first, saw_irlow;
    logic [63:0] qr[$];
    logic [2:0]  qi[$];
    k = 2; sent = 0; recv = 0; hold = 0; first = 0; saw_irlow = 0;
    for (int cyc = 0; cyc < 60 && recv < 6; cyc++) begin
      @(posedge clk); #1;
      inv[k] = (sent < 6);
      op = 3'($urandom_range(0, 4)); a = rand_operand(); b = rand_operand(); id = 3'(sent);
      if (ov[k]) first = 1'b1;
      ordy[k] = !(first && hold < 4);
      if (!ordy[k]) hold++;
      @(negedge clk);
      checks++;
      if (ir[k] !== !(ov[k] && !ordy[k])) begin
        errors++; $display("FAIL bp_in_ready cyc%0d: got %b expected %b", cyc, ir[k], !(ov[k] && !ordy[k]));
      end
      if (ir[k] === 1'b0) saw_irlow = 1'b1;
      if (ov[k]) begin
        checks++;
        if (qr.size() == 0 || res[k] !== qr[0] || tid[k] !== qi[0]) begin
          errors++; $display("FAIL bp_result cyc%0d: got %h/id%0d expected %h/id%0d", cyc, res[k], tid[k],
                             (qr.size() != 0) ? qr[0] : 64'h0, (qi.size() != 0) ? qi[0] : 3'h0);
        end
        if (ordy[k] && qr.size() != 0) begin void'(qr.pop_front()); void'(qi.pop_front()); recv++; end
      end
      if (inv[k] && ir[k]) begin qr.push_back(ref_res(64, op, a, b)); qi.push_back(id); sent++; end
    end
    checks++; if (recv != 6) begin errors++; $display("FAIL bp_count: got %0d expected 6", recv); end
    checks++; if (!saw_irlow) begin errors++; $display("FAIL bp_in_ready_drop: got never-low expected low"); end
    @(posedge clk); #1;
    inv[k] = 1'b0; ordy[k] = 1'b1;
    @(negedge clk);
    checks++; if (bsy[k] !== 1'b0) begin errors++; $display("FAIL bp_busy_clear: got %b expected 0", bsy[k]); end
  endtask

  task automatic test_flush;
    bit seen;
    // Two accepted and a third offered while flushing: nothing comes out.
    for (int k = 2; k < 4; k++) begin
      @(posedge clk); #1;
      inv[k] = 1'b1; ordy[k] = 1'b1; op = 3'd0; a = 64'd3; b = 64'd4; id = 3'd1;
      @(posedge clk); #1; id = 3'd2;
      @(posedge clk); #1; id = 3'd3; flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0; inv[k] = 1'b0;
      @(negedge clk);
      checks++;
      if (bsy[k] !== 1'b0 || ov[k] !== 1'b0) begin
        errors++; $display("FAIL flush_clear[%0d]: got busy=%b valid=%b expected 0/0", k, bsy[k], ov[k]);
      end
      seen = 1'b0;
      repeat (8) begin @(negedge clk); if (ov[k] !== 1'b0) seen = 1'b1; end
      checks++; if (seen) begin errors++; $display("FAIL flush_no_output[%0d]: got output expected none", k); end
      run_one(k, 3'd0, 64'd9, 64'd9, 3'd6, 64'd81, $sformatf("after_flush[%0d]", k));
    end
    // STAGES=1: flush in the same cycle as an output handshake.
    @(posedge clk); #1;
    inv[0] = 1'b1; ordy[0] = 1'b1; op = 3'd0; a = 64'd5; b = 64'd5; id = 3'd4;
    @(posedge clk); #1;
    id = 3'd7; a = 64'd11; flush = 1'b1;
    @(negedge clk);
    checks++;
    if (ov[0] !== 1'b1 || res[0] !== 64'd25 || tid[0] !== 3'd4) begin
      errors++; $display("FAIL flush_hs_output: got v=%b %h/id%0d expected 1 19/id4", ov[0], res[0], tid[0]);
    end
    @(posedge clk); #1;
    flush = 1'b0; inv[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (ov[0] !== 1'b0 || bsy[0] !== 1'b0) begin
      errors++; $display("FAIL flush_hs_clear: got valid=%b busy=%b expected 0/0", ov[0], bsy[0]);
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    @(posedge clk); #1;
    inv[3] = 1'b1; ordy[3] = 1'b1; op = 3'd0; a = 64'd2; b = 64'd3; id = 3'd1;
    repeat (3) @(posedge clk);
    #1;
    inv[3] = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if (bsy[3] !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", bsy[3]); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ov[3] !== 1'b0 || bsy[3] !== 1'b0 || ir[3] !== 1'b1) begin
      errors++; $display("FAIL midrst_state: got valid=%b busy=%b ready=%b expected 0/0/1", ov[3], bsy[3], ir[3]);
    end
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (ov[3] !== 1'b0) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL midrst_stale: got output expected none"); end
  endtask

  // Random valid/ready/flush traffic on instance k, scored against the
  // reference model through an in-order queue.
  task automatic test_random(input int k, input int n);
    logic [63:0] qr[$];
    logic [2:0]  qi[$];
    bit hs, acc;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      inv[k]  = ($urandom_range(0, 9) < 7);
      ordy[k] = ($urandom_range(0, 9) < 7);
      flush   = ($urandom_range(0, 39) == 0);
      op = 3'($urandom_range(0, 7)); a = rand_operand(); b = rand_operand(); id = 3'($urandom);
      @(negedge clk);
      checks++;
      if (bsy[k] !== (qr.size() != 0)) begin
        errors++; $display("FAIL rnd%0d_busy cyc%0d: got %b expected %b", k, i, bsy[k], qr.size() != 0);
      end
      checks++;
      if (ir[k] !== !(ov[k] && !ordy[k])) begin
        errors++; $display("FAIL rnd%0d_in_ready cyc%0d: got %b expected %b", k, i, ir[k], !(ov[k] && !ordy[k]));
      end
      if (ov[k]) begin
        checks++;
        if (qr.size() == 0 || res[k] !== qr[0] || tid[k] !== qi[0]) begin
          errors++; $display("FAIL rnd%0d_result cyc%0d: got %h/id%0d expected %h/id%0d", k, i, res[k], tid[k],
                             (qr.size() != 0) ? qr[0] : 64'h0, (qi.size() != 0) ? qi[0] : 3'h0);
        end
      end
      hs  = ov[k] && ordy[k];
      acc = inv[k] && ir[k] && !flush;
      if (hs && qr.size() != 0) begin void'(qr.pop_front()); void'(qi.pop_front()); end
      if (flush) begin qr.delete(); qi.delete(); end
      else if (acc) begin qr.push_back(ref_res(xlen_of(k), op, a, b)); qi.push_back(id); end
    end
    @(posedge clk); #1;
    inv[k] = 1'b0; flush = 1'b0; ordy[k] = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (ov[k]) begin
        checks++;
        if (qr.size() == 0 || res[k] !== qr[0] || tid[k] !== qi[0]) begin
          errors++; $display("FAIL rnd%0d_drain: got %h/id%0d expected %h/id%0d", k, res[k], tid[k],
                             (qr.size() != 0) ? qr[0] : 64'h0, (qi.size() != 0) ? qi[0] : 3'h0);
        end
        if (qr.size() != 0) begin void'(qr.pop_front()); void'(qi.pop_front()); end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (qr.size() != 0 || bsy[k] !== 1'b0) begin
      errors++; $display("FAIL rnd%0d_drained: got %0d pending busy=%b expected 0/0", k, qr.size(), bsy[k]);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; inv = '0; ordy = '1;
    op = 3'd0; a = '0; b = '0; id = '0;
    test_reset;
    test_basic;
    test_signed;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    for (int k = 0; k < 5; k++) test_random(k, 300);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mult_pipe.md
# mult_pipe

Parametrised, fully pipelined integer multiplier for the execute stage. It supports the RV64/RV32 M-extension multiply ops: MUL, MULH, MULHSU, MULHU and MULW. Latency is configurable through `STAGES`. Unlike the single-register multiplier, it has valid/ready back-pressure on both sides, a pipeline flush, an in-flight counter and a generic `XLEN`. It sits between issue and writeback, and its product registers are left for the synthesizer to retime.

## Interface
Parameters:
- `XLEN`, default 64: operand and result width; legal values are 32 and 64.
- `STAGES`, default 2: number of pipeline registers, 1..4; this equals the latency in cycles.
- `ID_W`, default 3: transaction-ID width.

Ports:
- `clk_i`  in  1  clock; all state changes on its rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `flush_i`  in  1  kill all in-flight and same-cycle input transactions.
- `in_valid_i`  in  1  input transaction present.
- `in_ready_o`  out  1  block can accept the input this cycle.
- `op_i`  in  3  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU, 4=MULW; 5..7 are reserved.
- `operand_a_i`  in  XLEN  rs1 value.
- `operand_b_i`  in  XLEN  rs2 value.
- `trans_id_i`  in  ID_W  transaction tag, returned unchanged with the result.
- `out_valid_o`  out  1  result present.
- `out_ready_i`  in  1  writeback accepts the result.
- `result_o`  out  XLEN  selected product bits.
- `trans_id_o`  out  ID_W  tag of the presented result.
- `busy_o`  out  1  at least one transaction is in flight.

## Operation
- Acceptance: a transaction is accepted when `in_valid_i & in_ready_o & !flush_i`.
- Sign control: operand a is sign-extended for MULH and MULHSU. Operand b is sign-extended for MULH only. All other ops are unsigned.
- Full product: {sa&a[XLEN-1], a} × {sb&b[XLEN-1], b}, signed, 2·XLEN bits wide.
- Result selection:
  - MUL: product[XLEN-1:0].
  - MULH, MULHSU, MULHU: product[2·XLEN-1:XLEN].
  - MULW: sign-extend of product[31:0] when XLEN=64; identical to MUL when XLEN=32.
  - Reserved ops 5..7 are accepted and produce the MUL result.
- Pipeline structure:
  - Stage 0 registers the full product, op, ID and valid bit.
  - Stages 1..STAGES-1 shift these fields forward.
  - Result selection is combinational after the last stage.
- Stall:
  - stall = v[STAGES-1] & !out_ready_i.
  - While stall is high, every stage holds its contents.
  - When stall is low, every stage advances and bubbles move with the data.
  - in_ready_o = !stall (a combinational path from `out_ready_i`).
- Flush: on the next edge, all valid bits clear. Any input presented in the same cycle is dropped. Data registers may keep stale values.
- In-flight counter: `cnt` is 0..STAGES. It increments on accept, decrements on output handshake, and is unchanged when both happen. It resets to 0 on flush. busy_o = (cnt != 0).
- Output handshake: a result is consumed when `out_valid_o & out_ready_i`. Results leave strictly in acceptance order.

## Timing
- Reset values:
  - `out_valid_o` = 0, `busy_o` = 0, `in_ready_o` = 1.
  - `result_o` = 0 and `trans_id_o` = 0 (data registers are cleared).
  - All stage valid bits and `cnt` are 0.
- Latency: an input accepted at edge N appears on `out_valid_o` after edge N+STAGES-1, i.e. in cycle N+STAGES. This assumes no stall.
- Throughput: one transaction per cycle while `out_ready_i` stays high.
- Held output: while out_valid_o=1 and out_ready_i=0, `result_o` and `trans_id_o` hold stable and in_ready_o=0.
- Full pipe: with all STAGES slots valid and the output stalled, nothing is lost. When `out_ready_i` rises, the drain resumes at one result per cycle.
- Simultaneous events:
  - Output handshake plus new accept in the same cycle: `cnt` is unchanged.
  - Flush plus output handshake in the same cycle: the output counts as consumed, and everything else is cleared.
  - Reset has priority over flush.
- Reset mid-operation: all in-flight transactions are discarded, with no output pulse. The block is ready in the cycle after reset deasserts.
- Back-pressure with bubbles: when out_valid_o=0, no stall occurs even if out_ready_i=0.

## Test plan
- Basic MUL, XLEN=64, STAGES=2: a=7, b=6, id=5 → out_valid_o high 2 cycles after accept, with result=42 and trans_id_o=5.
- Signed high products:
  - MULH with a=b=0xFFFF_FFFF_FFFF_FFFF → 0.
  - MULHU with the same operands → 0xFFFF_FFFF_FFFF_FFFE.
  - MULHSU with a=-1, b=2 → 0xFFFF_FFFF_FFFF_FFFF.
- MULW with a=0x8000_0000, b=1 → 0xFFFF_FFFF_8000_0000. With XLEN=32 the same op returns 0x8000_0000.
- Back-pressure, STAGES=3: stream ids 0..5 back-to-back and hold out_ready_i=0 for 4 cycles after the first result appears.
  - in_ready_o drops while the output is stalled.
  - All 6 results arrive in order with correct values.
  - busy_o clears after the last handshake.
- Flush: accept 2 transactions, then assert flush_i with in_valid_i=1.
  - No output ever appears.
  - cnt=0 and busy_o=0 one cycle later.
  - The next accepted transaction returns correctly after STAGES cycles.
- Reset mid-stream: assert rst_i with 3 in flight → out_valid_o=0 and busy_o=0 after the edge, with no stale results afterwards. Also run random constrained ops against a 2·XLEN-bit reference model for every STAGES value from 1 to 4.
